// File: rtl/seq_player.sv
// rtl/seq_player.sv - memory-game pattern generator: appends LFSR steps and plays the sequence on LEDs
module seq_player #(
    parameter int         DEPTH    = 16,
    parameter int         STEP_ON  = 8,
    parameter int         STEP_OFF = 4,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic                       CLR_SEQ,
    input  logic [$clog2(DEPTH)-1:0]   RD_IDX,
    output logic [7:0]                 RD_DATA,
    output logic [7:0]                 LEDS,
    output logic [$clog2(DEPTH):0]     LEN,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int IW      = $clog2(DEPTH);
    localparam int CNT_MAX = (STEP_ON > STEP_OFF) ? STEP_ON : STEP_OFF;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] ON_LAST  = CW'(STEP_ON - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(STEP_OFF - 1);
    localparam logic [IW:0]   FULL     = (IW + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPEND = 3'd1;
    localparam logic [2:0] S_SHOW   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [IW:0]   seq_len;
    logic [7:0]    lfsr;
    logic [7:0]    mem [DEPTH];

    logic          lfsr_fb;
    logic          seq_full;
    logic          last_step;
    logic          mem_we;

    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign seq_full  = (seq_len == FULL);
    assign last_step = (({1'b0, idx} + (IW + 1)'(1)) == seq_len);
    assign mem_we    = (state == S_APPEND) && !CLR_SEQ && !seq_full;

    // Free-running in every state so the player's reaction time seeds the pattern.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            seq_len <= '0;
            idx     <= '0;
            cnt     <= '0;
        end else if (CLR_SEQ) begin
            state   <= S_IDLE;
            seq_len <= '0;
            idx     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state <= S_APPEND;
                    end
                end
                S_APPEND: begin
                    if (!seq_full) begin
                        seq_len <= seq_len + (IW + 1)'(1);
                    end
                    idx   <= '0;
                    cnt   <= '0;
                    state <= S_SHOW;
                end
                S_SHOW: begin
                    if (cnt == ON_LAST) begin
                        cnt   <= '0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == OFF_LAST) begin
                        cnt <= '0;
                        if (last_step) begin
                            state <= S_FIN;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= S_SHOW;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Step storage survives reset and CLR_SEQ; only LEN marks what is valid.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[seq_len[IW-1:0]] <= lfsr;
        end
    end

    assign RD_DATA = mem[RD_IDX];
    assign LEDS    = (state == S_SHOW) ? mem[idx] : 8'h00;
    assign LEN     = seq_len;
    assign BUSY    = (state != S_IDLE);
    assign DONE    = (state == S_FIN);

endmodule

// File: tb/tb_seq_player.sv
// tb/tb_seq_player.sv - self-checking bench for seq_player against a queue-based sequence model
module tb_seq_player;

    localparam int ON  = 8;
    localparam int OFF = 4;
    localparam int PER = ON + OFF;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       start = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] rd_idx = 4'd0;
    logic [7:0] rd_data, leds;
    logic [4:0] len;
    logic       busy, done;

    logic       start4 = 1'b0;
    logic       clr4 = 1'b0;
    logic [1:0] rd_idx4 = 2'd0;
    logic [7:0] rd_data4, leds4;
    logic [2:0] len4;
    logic       busy4, done4;

    int cyc;
    int tests = 0;
    int fails = 0;

    logic [7:0] mq[$];
    logic [7:0] q4[$];
    logic [7:0] obs_leds[$];
    logic       obs_busy[$];
    logic       obs_done[$];
    logic [4:0] obs_len[$];

    seq_player dut (
        .CLK(CLK), .RST(RST), .START(start), .CLR_SEQ(clr), .RD_IDX(rd_idx),
        .RD_DATA(rd_data), .LEDS(leds), .LEN(len), .BUSY(busy), .DONE(done)
    );

    seq_player #(.DEPTH(4)) dut4 (
        .CLK(CLK), .RST(RST), .START(start4), .CLR_SEQ(clr4), .RD_IDX(rd_idx4),
        .RD_DATA(rd_data4), .LEDS(leds4), .LEN(len4), .BUSY(busy4), .DONE(done4)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RST) begin
        if (!RST) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // LFSR value present in the cycle after n rising edges since reset release
    function automatic logic [7:0] lfsr_at(int n);
        logic [7:0] v = 8'hA5;
        for (int k = 0; k < n; k++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    // {leds, busy, done} for cycle i counted from the first SHOW cycle of an n-step playback
    function automatic logic [9:0] exp_trace(int i, int n, logic [7:0] v);
        if (i < n * PER) return {((i % PER) < ON) ? v : 8'h00, 1'b1, 1'b0};
        if (i == n * PER) return {8'h00, 1'b1, 1'b1};
        return {8'h00, 2'b00};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic record(input int n, input bit use4);
        obs_leds.delete(); obs_busy.delete(); obs_done.delete(); obs_len.delete();
        for (int i = 0; i < n; i++) begin
            if (use4) begin
                obs_leds.push_back(leds4); obs_busy.push_back(busy4);
                obs_done.push_back(done4); obs_len.push_back({2'b00, len4});
            end else begin
                obs_leds.push_back(leds); obs_busy.push_back(busy);
                obs_done.push_back(done); obs_len.push_back(len);
            end
            tick();
        end
    endtask

    task automatic play_round(input bit use4, output logic [7:0] app, output logic app_busy);
        if (use4) start4 = 1'b1; else start = 1'b1;
        tick();
        app = lfsr_at(cyc);
        app_busy = use4 ? busy4 : busy;
        if (use4) begin
            if (q4.size() < 4) q4.push_back(app);
        end else begin
            if (mq.size() < 16) mq.push_back(app);
        end
        start = 1'b0;
        start4 = 1'b0;
        tick();
        record((use4 ? q4.size() : mq.size()) * PER + 2, use4);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        mq.delete();
        q4.delete();
    endtask

    task automatic test_reset();
        logic [7:0] app;
        logic ab;
        int nb, nd;
        tick();
        tick();
        tests++; if (leds !== 8'h00) begin fails++; $display("FAIL reset_leds got %h exp 00", leds); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (len !== 5'd0) begin fails++; $display("FAIL reset_len got %0d exp 0", len); end
        tests++; if (len4 !== 3'd0) begin fails++; $display("FAIL reset_len4 got %0d exp 0", len4); end
        RST = 1'b1;
        play_round(1'b0, app, ab);
        tests++; if (obs_len[0] !== 5'd1) begin fails++; $display("FAIL first_len got %0d exp 1", obs_len[0]); end
        rd_idx = 4'd0; #1;
        tests++; if (rd_data !== 8'h4A) begin fails++; $display("FAIL first_append got %h exp 4a", rd_data); end
        nb = int'(ab); nd = 0;
        for (int i = 0; i < obs_leds.size(); i++) begin
            logic [9:0] e;
            int s;
            s = i / PER;
            e = exp_trace(i, mq.size(), (s < mq.size()) ? mq[s] : 8'h00);
            nb += int'(obs_busy[i]);
            nd += int'(obs_done[i]);
            tests++;
            if ({obs_leds[i], obs_busy[i], obs_done[i]} !== e) begin
                fails++; $display("FAIL first_trace cyc %0d got %h exp %h", i, {obs_leds[i], obs_busy[i], obs_done[i]}, e);
            end
        end
        tests++; if (nb != 14) begin fails++; $display("FAIL first_busy_cycles got %0d exp 14", nb); end
        tests++; if (nd != 1) begin fails++; $display("FAIL first_done_pulses got %0d exp 1", nd); end
    endtask

    task automatic test_three_rounds();
        logic [7:0] app;
        logic ab;
        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(0, 7)) tick();
            play_round(1'b0, app, ab);
        end
        tests++; if (len !== 5'd3) begin fails++; $display("FAIL three_len got %0d exp 3", len); end
        tests++; if (obs_len[0] !== 5'd3) begin fails++; $display("FAIL three_len_show got %0d exp 3", obs_len[0]); end
        for (int i = 0; i < obs_leds.size(); i++) begin
            logic [9:0] e;
            int s;
            s = i / PER;
            e = exp_trace(i, mq.size(), (s < mq.size()) ? mq[s] : 8'h00);
            tests++;
            if ({obs_leds[i], obs_busy[i], obs_done[i]} !== e) begin
                fails++; $display("FAIL three_trace cyc %0d got %h exp %h", i, {obs_leds[i], obs_busy[i], obs_done[i]}, e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            rd_idx = 4'(i); #1;
            tests++; if (rd_data !== mq[i]) begin fails++; $display("FAIL three_rd idx %0d got %h exp %h", i, rd_data, mq[i]); end
        end
        rd_idx = 4'd0; #1;
        tests++; if (rd_data !== 8'h4A) begin fails++; $display("FAIL three_mem0 got %h exp 4a", rd_data); end
    endtask

    task automatic test_clear_mid_show();
        logic [7:0] app;
        logic ab;
        int nd;
        clr = 1'b1; tick(); clr = 1'b0;
        mq.delete();
        tests++; if (len !== 5'd0) begin fails++; $display("FAIL clr_len got %0d exp 0", len); end
        play_round(1'b0, app, ab);
        start = 1'b1; tick(); start = 1'b0;
        app = lfsr_at(cyc);
        tick(); tick(); tick();
        tests++; if (leds !== mq[0]) begin fails++; $display("FAIL clr_show3 got %h exp %h", leds, mq[0]); end
        tests++; if (len !== 5'd2) begin fails++; $display("FAIL clr_len2 got %0d exp 2", len); end
        clr = 1'b1; tick(); clr = 1'b0;
        mq.delete();
        tests++; if (leds !== 8'h00) begin fails++; $display("FAIL clr_leds got %h exp 00", leds); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL clr_busy got %b exp 0", busy); end
        tests++; if (len !== 5'd0) begin fails++; $display("FAIL clr_len_after got %0d exp 0", len); end
        nd = 0;
        for (int i = 0; i < 3 * PER; i++) begin
            nd += int'(done);
            tick();
        end
        tests++; if (nd != 0) begin fails++; $display("FAIL clr_no_done got %0d exp 0", nd); end
        play_round(1'b0, app, ab);
        tests++; if (len !== 5'd1) begin fails++; $display("FAIL clr_restart_len got %0d exp 1", len); end
        rd_idx = 4'd0; #1;
        tests++; if (rd_data !== app) begin fails++; $display("FAIL clr_restart_mem0 got %h exp %h", rd_data, app); end
    endtask

    task automatic test_start_clear_idle();
        logic [7:0] app;
        logic ab;
        repeat ($urandom_range(0, 5)) tick();
        play_round(1'b0, app, ab);
        tests++; if (len !== 5'd2) begin fails++; $display("FAIL both_len2 got %0d exp 2", len); end
        start = 1'b1; clr = 1'b1; tick(); start = 1'b0; clr = 1'b0;
        mq.delete();
        tests++; if (len !== 5'd0) begin fails++; $display("FAIL both_len got %0d exp 0", len); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL both_busy got %b exp 0", busy); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL both_idle_hold got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] app;
        repeat ($urandom_range(1, 6)) tick();
        start = 1'b1;
        tick();
        for (int k = 1; k <= 3; k++) begin
            app = lfsr_at(cyc);
            mq.push_back(app);
            record(k * PER + 3, 1'b0);
            for (int i = 0; i < obs_leds.size(); i++) begin
                logic [9:0] e;
                int s;
                s = (i - 1) / PER;
                if (i == 0) e = {8'h00, 1'b1, 1'b0};
                else e = exp_trace(i - 1, k, (s < k) ? mq[s] : 8'h00);
                tests++;
                if ({obs_leds[i], obs_busy[i], obs_done[i]} !== e) begin
                    fails++; $display("FAIL b2b_trace round %0d cyc %0d got %h exp %h", k, i, {obs_leds[i], obs_busy[i], obs_done[i]}, e);
                end
            end
        end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_append4 got %b exp 1", busy); end
        tick();
        repeat (ON) tick();
        tick();
        RST = 1'b0; #1;
        tests++; if (leds !== 8'h00) begin fails++; $display("FAIL rst_gap_leds got %h exp 00", leds); end
        tests++; if (len !== 5'd0) begin fails++; $display("FAIL rst_gap_len got %0d exp 0", len); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_gap_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_gap_done got %b exp 0", done); end
        tick();
        RST = 1'b1;
        mq.delete();
        q4.delete();
        tick();
        start = 1'b0;
        tick();
        rd_idx = 4'd0; #1;
        tests++; if (rd_data !== 8'h4A) begin fails++; $display("FAIL rst_lfsr_seed got %h exp 4a", rd_data); end
        tests++; if (leds !== 8'h4A) begin fails++; $display("FAIL rst_replay_leds got %h exp 4a", leds); end
        tests++; if (len !== 5'd1) begin fails++; $display("FAIL rst_replay_len got %0d exp 1", len); end
        repeat (PER + 1) tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_replay_end got %b exp 0", busy); end
    endtask

    task automatic test_saturate();
        logic [7:0] app;
        logic ab;
        do_reset();
        for (int r = 1; r <= 5; r++) begin
            repeat ($urandom_range(0, 5)) tick();
            play_round(1'b1, app, ab);
            tests++;
            if (len4 !== 3'((r < 4) ? r : 4)) begin
                fails++; $display("FAIL sat_len round %0d got %0d exp %0d", r, len4, (r < 4) ? r : 4);
            end
            for (int i = 0; i < obs_leds.size(); i++) begin
                logic [9:0] e;
                int s;
                s = i / PER;
                e = exp_trace(i, q4.size(), (s < q4.size()) ? q4[s] : 8'h00);
                tests++;
                if ({obs_leds[i], obs_busy[i], obs_done[i]} !== e) begin
                    fails++; $display("FAIL sat_trace round %0d cyc %0d got %h exp %h", r, i, {obs_leds[i], obs_busy[i], obs_done[i]}, e);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx4 = 2'(i); #1;
            tests++; if (rd_data4 !== q4[i]) begin fails++; $display("FAIL sat_rd idx %0d got %h exp %h", i, rd_data4, q4[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_three_rounds();
        test_clear_mid_show();
        test_start_clear_idle();
        test_back_to_back();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_player.md
# seq_player

Pattern generator and playback engine for the memory game: the driving end of the player-input path. On each round request it appends one pseudo-random 8-bit step to an internal sequence. It then plays the whole sequence back on the LEDs, one step at a time with fixed on/off timing. The stored steps are exposed through a read port so the comparison logic can fetch the expected pattern. It runs on the divided game clock, alongside the switch-entry and detection logic.

## Interface
- `DEPTH`, 16: maximum sequence length (steps); power of two, 2..64
- `STEP_ON`, 8: CLK cycles each step is shown (≥1)
- `STEP_OFF`, 4: CLK cycles of blank gap after each step (≥1)
- `SEED`, 8'hA5: LFSR reset value (must be nonzero)
- `CLK`  input  1  game clock (divided clock); all logic on rising edge
- `RST`  input  1  asynchronous, active-low reset
- `START`  input  1  round request; level sampled each cycle, acted on only in IDLE
- `CLR_SEQ`  input  1  synchronous new-game: empties sequence, aborts playback
- `RD_IDX`  input  $clog2(DEPTH)  read address into stored sequence
- `RD_DATA`  output  8  mem[RD_IDX], combinational; undefined if RD_IDX ≥ LEN
- `LEDS`  output  8  active-high pattern being displayed (top level inverts for the board)
- `LEN`  output  $clog2(DEPTH)+1  number of stored steps
- `BUSY`  output  1  high whenever state ≠ IDLE
- `DONE`  output  1  one-cycle pulse after the final gap of a playback

## Operation
- LFSR: 8-bit Fibonacci LFSR, shifted left; new bit0 = b7^b5^b4^b3. It advances every CLK cycle, free-running in all states, so player timing seeds the randomness. It is never zero.
- States: IDLE, APPEND, SHOW, GAP, FIN.
- IDLE: LEDS = 0. START=1 → APPEND.
- APPEND (1 cycle):
  - If LEN < DEPTH: mem[LEN] ← current (pre-advance) LFSR value, and LEN ← LEN+1.
  - If LEN == DEPTH: no write; the existing sequence is replayed.
  - In both cases: idx ← 0, cnt ← 0, → SHOW.
- SHOW: LEDS = mem[idx]. cnt counts 0..STEP_ON-1; at STEP_ON-1, cnt ← 0 and → GAP.
- GAP: LEDS = 0. cnt counts 0..STEP_OFF-1. At the end:
  - if idx == LEN-1 → FIN;
  - else idx ← idx+1 and → SHOW.
- FIN (1 cycle): DONE = 1, → IDLE.
- START is ignored outside IDLE. A START held high through FIN starts the next round immediately on return to IDLE.
- CLR_SEQ, in any state and with priority over START: LEN ← 0, idx ← 0, cnt ← 0, → IDLE. It does not reset the LFSR or clear memory contents.
- Reset (RST=0, asynchronous) clears all of:
  - state = IDLE, LEN = 0, idx = 0, cnt = 0, LFSR = SEED
  - LEDS = 0, BUSY = 0, DONE = 0
  - Memory contents are not reset.
- LEDS, BUSY and DONE are decoded combinationally from registered state/idx; they carry no glitch-free guarantee beyond that.

## Timing
- START high during IDLE cycle t → APPEND in cycle t+1 → SHOW from cycle t+2.
- LEDS show mem[0] for cycles t+2 .. t+1+STEP_ON.
- Playback occupies LEN×(STEP_ON+STEP_OFF) cycles from the first SHOW cycle. DONE is high in the cycle after the last GAP cycle, and IDLE follows one cycle later.
- BUSY is high from cycle t+1 through the FIN cycle inclusive.
- LEN updates at the end of APPEND and is visible from the first SHOW cycle onward.
- RD_DATA tracks writes one cycle after APPEND.
- Reset mid-playback: outputs return to reset values immediately, with no DONE.

## Test plan
- Reset, then START=1 in the first cycle after RST release. Required: APPEND captures 8'h4A (SEED A5 → 4A); LEN=1; LEDS=8'h4A for 8 cycles, then 0 for 4 cycles; DONE pulses 1 cycle; BUSY high for 14 cycles total.
- Three rounds, with START pulsed for 1 cycle each time after DONE. Required: LEN=3; playback shows mem[0], mem[1], mem[2] in order, 36 cycles of SHOW/GAP; RD_IDX=0..2 returns the same three values; mem[0] is unchanged across rounds.
- With DEPTH=4 parameterisation, run 5 rounds. Required: LEN saturates at 4; the 5th round writes nothing and replays the 4 stored steps exactly.
- CLR_SEQ asserted on the 3rd SHOW cycle of a LEN=2 playback. Required: next cycle LEDS=0, BUSY=0, LEN=0, and no DONE. A following START appends at mem[0] and gives LEN=1.
- START and CLR_SEQ high together in IDLE with LEN=2. Required: clear wins; LEN=0, state stays IDLE for that cycle.
- START held high continuously. Required: back-to-back rounds, IDLE lasting exactly 1 cycle between FIN and APPEND. RST pulsed low mid-GAP: immediate LEDS=0, LEN=0, and LFSR back to 8'hA5.
